// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Inter-stage pipeline register with valid/ready handshake,
//               2-entry skid buffer, flush, bubble insertion and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
   parameter int CTRL_W              = 9,
   parameter int DATA_W              = 88,
   parameter int ZERO_DATA_ON_BUBBLE = 0,
   parameter int CNT_W               = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_cnt_clr
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [1:0]        r_occupancy;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // Handshake flags are registered per state so in_ready never sees out_ready.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occupancy <= 2'd0;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else if (flush) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occupancy <= 2'd0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
                  r_state     <= ST_BUSY;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b1;
                  r_occupancy <= 2'd1;
               end
            end
            ST_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
               end else if (w_in_fire) begin
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
                  r_state     <= ST_FULL;
                  r_in_ready  <= 1'b0;
                  r_occupancy <= 2'd2;
               end else if (w_out_fire) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
                  r_occupancy <= 2'd0;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                  r_state     <= ST_BUSY;
                  r_in_ready  <= 1'b1;
                  r_occupancy <= 2'd1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_occupancy <= 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (stall_cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign occupancy = r_occupancy;
   assign stall_cnt = r_stall_cnt;
   assign out_ctrl  = r_out_valid ? r_main_ctrl : '0;

   generate
      if (ZERO_DATA_ON_BUBBLE != 0) begin : g_zero_data
         assign out_data = r_out_valid ? r_main_data : '0;
      end else begin : g_hold_data
         assign out_data = r_main_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// Bench for pipe_skid_stage: three instances (hold data, zero data, 4-bit counter)
// checked every cycle against a queue model plus directed literal checks.
module tb_pipe_skid_stage;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [8:0]   in_ctrl = '0;
   logic [87:0]  in_data = '0;
   logic         out_ready = 1'b0;
   logic         flush = 1'b0;
   logic         stall_cnt_clr = 1'b0;

   logic         a_in_ready, z_in_ready, c_in_ready;
   logic         a_out_valid, z_out_valid, c_out_valid;
   logic [8:0]   a_out_ctrl, z_out_ctrl, c_out_ctrl;
   logic [87:0]  a_out_data, z_out_data, c_out_data;
   logic [1:0]   a_occ, z_occ, c_occ;
   logic [15:0]  a_cnt, z_cnt;
   logic [3:0]   c_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pipe_skid_stage dut_a (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .flush(flush), .occupancy(a_occ),
      .stall_cnt(a_cnt), .stall_cnt_clr(stall_cnt_clr));

   pipe_skid_stage #(.ZERO_DATA_ON_BUBBLE(1)) dut_z (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
      .out_ctrl(z_out_ctrl), .out_data(z_out_data), .flush(flush), .occupancy(z_occ),
      .stall_cnt(z_cnt), .stall_cnt_clr(stall_cnt_clr));

   pipe_skid_stage #(.CNT_W(4)) dut_c (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_ctrl(c_out_ctrl), .out_data(c_out_data), .flush(flush), .occupancy(c_occ),
      .stall_cnt(c_cnt), .stall_cnt_clr(stall_cnt_clr));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries, head is the visible output.
   typedef struct packed {
      logic [8:0]  c;
      logic [87:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [87:0] m_last = '0;
   int          m_cnt16 = 0;
   int          m_cnt4 = 0;

   always @(negedge reset) begin
      mq.delete();
      m_last  = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
   end

   always @(posedge clock) begin
      if (!reset) begin
         mq.delete();
         m_last  = '0;
         m_cnt16 = 0;
         m_cnt4  = 0;
      end else begin
         automatic bit   v     = (mq.size() > 0);
         automatic bit   rdy   = (mq.size() < 2);
         automatic bit   infr  = in_valid && rdy;
         automatic bit   outfr = v && out_ready;
         automatic ent_t e;
         e.c = in_ctrl;
         e.d = in_data;
         if (stall_cnt_clr) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
         end else if (v && !out_ready) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (flush) begin
            mq.delete();
         end else begin
            if (outfr) void'(mq.pop_front());
            if (infr) mq.push_back(e);
            if (mq.size() > 0) m_last = mq[0].d;
         end
      end
   end

   always @(negedge clock) begin
      automatic bit          v  = (mq.size() > 0);
      automatic logic [8:0]  ec = v ? mq[0].c : 9'd0;
      automatic logic [87:0] ed = v ? mq[0].d : m_last;
      automatic logic [87:0] ez = v ? mq[0].d : 88'd0;
      chk("a_out_valid", a_out_valid, v);
      chk("a_in_ready", a_in_ready, mq.size() < 2);
      chk("a_occupancy", a_occ, mq.size());
      chk("a_out_ctrl", a_out_ctrl, ec);
      chk("a_out_data", a_out_data, ed);
      chk("a_stall_cnt", a_cnt, m_cnt16);
      chk("z_out_ctrl", z_out_ctrl, ec);
      chk("z_out_data", z_out_data, ez);
      chk("z_in_ready", z_in_ready, mq.size() < 2);
      chk("z_stall_cnt", z_cnt, m_cnt16);
      chk("c_out_valid", c_out_valid, v);
      chk("c_occupancy", c_occ, mq.size());
      chk("c_out_data", c_out_data, ed);
      chk("c_stall_cnt", c_cnt, m_cnt4);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      tick();
      chk("rst_out_valid", a_out_valid, 1'b0);
      chk("rst_occupancy", a_occ, 2'd0);
      chk("rst_stall_cnt", a_cnt, 16'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_in_ready", a_in_ready, 1'b1);

      // Streaming with no backpressure
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 9'h1A5;
      for (int i = 1; i <= 8; i++) begin
         in_data = 88'(i);
         tick();
         chk("stream_valid", a_out_valid, 1'b1);
         chk("stream_data", a_out_data, 88'(i));
         chk("stream_ctrl", a_out_ctrl, 9'h1A5);
         chk("stream_ready", a_in_ready, 1'b1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain_valid", a_out_valid, 1'b0);
      chk("stream_stall", a_cnt, 16'd0);

      // Bubble data after 0xBEEF
      in_valid = 1'b1;
      in_ctrl  = 9'h00F;
      in_data  = 88'hBEEF;
      tick();
      in_valid = 1'b0;
      tick();
      chk("bubble_ctrl_a", a_out_ctrl, 9'd0);
      chk("bubble_ctrl_z", z_out_ctrl, 9'd0);
      chk("bubble_data_a", a_out_data, 88'hBEEF);
      chk("bubble_data_z", z_out_data, 88'd0);

      // Backpressure into the skid entry
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 9'h011;
      in_data   = 88'h11;
      tick();
      chk("bp_occ1", a_occ, 2'd1);
      in_ctrl = 9'h022;
      in_data = 88'h22;
      tick();
      chk("bp_occ2", a_occ, 2'd2);
      chk("bp_in_ready", a_in_ready, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("bp_hold_data", a_out_data, 88'h11);
      chk("bp_stall", a_cnt, 16'd2);
      out_ready = 1'b1;
      tick();
      chk("bp_second", a_out_data, 88'h22);
      chk("bp_occ_after", a_occ, 2'd1);
      tick();
      chk("bp_empty", a_occ, 2'd0);
      chk("bp_stall_final", a_cnt, 16'd2);

      // Flush while FULL with an offered entry
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 9'h044;
      in_data   = 88'h44;
      tick();
      in_data = 88'h55;
      tick();
      in_data = 88'h66;
      flush   = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", a_occ, 2'd0);
      chk("flush_valid", a_out_valid, 1'b0);
      chk("flush_ctrl", a_out_ctrl, 9'd0);
      chk("flush_stall_kept", a_cnt, 16'd4);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_ctrl   = 9'h033;
      in_data   = 88'h33;
      tick();
      chk("post_flush_data", a_out_data, 88'h33);
      chk("post_flush_ctrl", a_out_ctrl, 9'h033);
      in_data = 88'h77;
      flush   = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_busy_occ", a_occ, 2'd0);
      tick();

      // Stall counter saturation and clear
      stall_cnt_clr = 1'b1;
      tick();
      stall_cnt_clr = 1'b0;
      chk("clr_zero", c_cnt, 4'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 9'h088;
      in_data   = 88'h88;
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat_c", c_cnt, 4'd15);
      chk("nosat_a", a_cnt, 16'd20);
      stall_cnt_clr = 1'b1;
      tick();
      stall_cnt_clr = 1'b0;
      chk("clr_prio", c_cnt, 4'd0);
      tick();
      chk("clr_then_inc", c_cnt, 4'd1);

      // Asynchronous reset while FULL
      in_valid = 1'b1;
      in_ctrl  = 9'h099;
      in_data  = 88'h99;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_occ", a_occ, 2'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", a_out_valid, 1'b0);
      chk("arst_occ", a_occ, 2'd0);
      chk("arst_ctrl", a_out_ctrl, 9'd0);
      chk("arst_data", a_out_data, 88'd0);
      chk("arst_cnt", a_cnt, 16'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("arst_ready", a_in_ready, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 9'h0AB;
      in_data   = 88'hAB;
      tick();
      in_valid = 1'b0;
      chk("arst_first_valid", a_out_valid, 1'b1);
      chk("arst_first_data", a_out_data, 88'hAB);
      tick();
      chk("arst_drain", a_out_valid, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
